sipo_deser: RTL and testbench

SIPO_DESER -- requirements
Module: sipo_deser

---
 rtl/sipo_deser.sv | 118 +++++++++++
 tb/tb_sipo_deser.sv | 216 +++++++++++++++++++++
 2 files changed

// File: rtl/sipo_deser.sv
// Serial-in/parallel-out deserializer with a one-word output register, valid/ready handoff and a sticky overrun flag.
// Define SIPO_PARITY_EN to take an extra even-parity bit per word and add the parity_err output.
module sipo_deser #(
    parameter int WIDTH     = 4,
    parameter bit MSB_FIRST = 1'b1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             sin,
    input  logic             sin_en,
    input  logic             flush,
    output logic [WIDTH-1:0] pout,
    output logic             pout_valid,
    input  logic             pout_ready,
    output logic             overrun,
    output logic             busy
`ifdef SIPO_PARITY_EN
    ,
    output logic             parity_err
`endif
);

    localparam int CW = $clog2(WIDTH);
    localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

`ifdef SIPO_PARITY_EN
    typedef enum logic {COLLECT, PARITY} state_t;
`else
    typedef enum logic {COLLECT} state_t;
`endif

    state_t           state, state_next;
    logic [CW-1:0]    cnt, cnt_next;
    logic [WIDTH-1:0] sreg, sreg_next, shifted, word;
    logic             complete, perr_next;

    always_comb begin
        state_next = state;
        cnt_next   = cnt;
        sreg_next  = sreg;
        complete   = 1'b0;
        perr_next  = 1'b0;
        shifted    = MSB_FIRST ? {sreg[WIDTH-2:0], sin} : {sin, sreg[WIDTH-1:1]};
`ifdef SIPO_PARITY_EN
        // The data bits are already in sreg by the time the parity bit arrives.
        word       = sreg;
`else
        word       = shifted;
`endif
        if (flush) begin
            cnt_next   = '0;
            state_next = COLLECT;
        end else if (sin_en) begin
`ifdef SIPO_PARITY_EN
            if (state == PARITY) begin
                state_next = COLLECT;
                if (sin == ^sreg) complete  = 1'b1;
                else              perr_next = 1'b1;
            end else begin
`endif
                sreg_next = shifted;
                if (cnt == LAST) begin
                    cnt_next = '0;
`ifdef SIPO_PARITY_EN
                    state_next = PARITY;
`else
                    complete = 1'b1;
`endif
                end else begin
                    cnt_next = cnt + 1'b1;
                end
`ifdef SIPO_PARITY_EN
            end
`endif
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state      <= COLLECT;
            cnt        <= '0;
            sreg       <= '0;
            pout       <= '0;
            pout_valid <= 1'b0;
            overrun    <= 1'b0;
`ifdef SIPO_PARITY_EN
            parity_err <= 1'b0;
`endif
        end else begin
            state <= state_next;
            cnt   <= cnt_next;
            sreg  <= sreg_next;
`ifdef SIPO_PARITY_EN
            parity_err <= perr_next;
`endif
            // A word completing while the consumer takes the old one replaces it with no gap in valid.
            if (complete) begin
                if (!pout_valid || pout_ready) begin
                    pout       <= word;
                    pout_valid <= 1'b1;
                end else begin
                    overrun <= 1'b1;
                end
            end else if (pout_valid && pout_ready) begin
                pout_valid <= 1'b0;
            end
        end
    end

`ifdef SIPO_PARITY_EN
    assign busy = (cnt != '0) || (state == PARITY);
`else
    assign busy = (cnt != '0);
    logic unused_perr;
    assign unused_perr = perr_next;
`endif

endmodule

// File: tb/tb_sipo_deser.sv
// Bench for sipo_deser: MSB-first and LSB-first instances share one input stream and are
// checked every cycle against a queue-based word model, plus directed constant checks.
module tb_sipo_deser;

    localparam int W = 4;
`ifdef SIPO_PARITY_EN
    localparam int PB = 1;
`else
    localparam int PB = 0;
`endif

    logic clk = 1'b0;
    logic rst = 1'b0;
    logic sin = 1'b0, sin_en = 1'b0, flush = 1'b0, pout_ready = 1'b0;
    logic [W-1:0] pout_m, pout_l;
    logic valid_m, valid_l, ovr_m, ovr_l, busy_m, busy_l;
`ifdef SIPO_PARITY_EN
    logic perr_m, perr_l;
`endif

    int n_assert = 0;
    int n_fail   = 0;

    bit           q[$];
    logic [W-1:0] m_pout_m = '0, m_pout_l = '0;
    logic         m_valid = 1'b0, m_ovr = 1'b0, m_perr = 1'b0;

    sipo_deser #(.WIDTH(W), .MSB_FIRST(1'b1)) dut_msb (
        .clk(clk), .rst(rst), .sin(sin), .sin_en(sin_en), .flush(flush),
        .pout(pout_m), .pout_valid(valid_m), .pout_ready(pout_ready),
        .overrun(ovr_m), .busy(busy_m)
`ifdef SIPO_PARITY_EN
        , .parity_err(perr_m)
`endif
    );

    sipo_deser #(.WIDTH(W), .MSB_FIRST(1'b0)) dut_lsb (
        .clk(clk), .rst(rst), .sin(sin), .sin_en(sin_en), .flush(flush),
        .pout(pout_l), .pout_valid(valid_l), .pout_ready(pout_ready),
        .overrun(ovr_l), .busy(busy_l)
`ifdef SIPO_PARITY_EN
        , .parity_err(perr_l)
`endif
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        q.delete();
        m_pout_m = '0;
        m_pout_l = '0;
        m_valid  = 1'b0;
        m_ovr    = 1'b0;
        m_perr   = 1'b0;
    endtask

    // One clock edge of the behavioural model: bits accumulate in a queue, a full
    // queue becomes a word (plus parity check when enabled).
    task automatic model_edge(input logic b, input logic en, input logic fl, input logic rdy);
        logic         cmp = 1'b0;
        logic         par = 1'b0;
        logic         ok;
        logic [W-1:0] wm = '0, wl = '0;
        m_perr = 1'b0;
        if (fl) begin
            q.delete();
        end else if (en) begin
            q.push_back(b);
            if (q.size() == W + PB) begin
                for (int i = 0; i < W; i++) begin
                    wm[W-1-i] = q[i];
                    wl[i]     = q[i];
                    par       = par ^ q[i];
                end
                ok = (PB == 0) || (q[W] == par);
                q.delete();
                if (ok) cmp = 1'b1;
                else    m_perr = 1'b1;
            end
        end
        if (cmp) begin
            if (!m_valid || rdy) begin
                m_pout_m = wm;
                m_pout_l = wl;
                m_valid  = 1'b1;
            end else begin
                m_ovr = 1'b1;
            end
        end else if (m_valid && rdy) begin
            m_valid = 1'b0;
        end
    endtask

    task automatic check_all(input string tag);
        check({tag, ".pout_m"},  32'(pout_m),  32'(m_pout_m));
        check({tag, ".valid_m"}, 32'(valid_m), 32'(m_valid));
        check({tag, ".ovr_m"},   32'(ovr_m),   32'(m_ovr));
        check({tag, ".busy_m"},  32'(busy_m),  32'(q.size() != 0));
        check({tag, ".pout_l"},  32'(pout_l),  32'(m_pout_l));
        check({tag, ".valid_l"}, 32'(valid_l), 32'(m_valid));
        check({tag, ".ovr_l"},   32'(ovr_l),   32'(m_ovr));
        check({tag, ".busy_l"},  32'(busy_l),  32'(q.size() != 0));
`ifdef SIPO_PARITY_EN
        check({tag, ".perr_m"},  32'(perr_m),  32'(m_perr));
        check({tag, ".perr_l"},  32'(perr_l),  32'(m_perr));
`endif
    endtask

    task automatic cycle(input logic b, input logic en, input logic fl, input logic rdy, input string tag);
        sin        = b;
        sin_en     = en;
        flush      = fl;
        pout_ready = rdy;
        @(posedge clk);
        model_edge(b, en, fl, rdy);
        #1;
        check_all(tag);
    endtask

    // Sends w[W-1] first; rdy_last applies to the completing bit (parity bit if enabled).
    task automatic send_word(input logic [W-1:0] w, input logic rdy, input logic rdy_last, input string tag);
        logic last;
        for (int i = 0; i < W; i++) begin
            last = (i == W - 1) && (PB == 0);
            cycle(w[W-1-i], 1'b1, 1'b0, last ? rdy_last : rdy, tag);
        end
`ifdef SIPO_PARITY_EN
        cycle(^w, 1'b1, 1'b0, rdy_last, {tag, ".par"});
`endif
    endtask

    initial begin
        #12;
        model_reset();
        check_all("reset");
        @(negedge clk);
        rst = 1'b1;

        send_word(4'b1100, 1'b1, 1'b1, "w1100");
        check("w1100.pout", 32'(pout_m), 32'h0000000c);
        check("w1100.valid", 32'(valid_m), 32'd1);
        cycle(1'b0, 1'b0, 1'b0, 1'b1, "w1100.take");
        check("w1100.one_cycle", 32'(valid_m), 32'd0);

        send_word(4'b0001, 1'b0, 1'b0, "w0001");
        send_word(4'b1110, 1'b0, 1'b0, "w1110");
        check("ovr.pout_kept", 32'(pout_m), 32'h00000001);
        check("ovr.flag", 32'(ovr_m), 32'd1);
        cycle(1'b0, 1'b0, 1'b0, 1'b0, "ovr.wait");
        check("ovr.valid_held", 32'(valid_m), 32'd1);
        cycle(1'b0, 1'b0, 1'b0, 1'b1, "ovr.take");

        cycle(1'b1, 1'b1, 1'b0, 1'b0, "rst.b0");
        cycle(1'b0, 1'b1, 1'b0, 1'b0, "rst.b1");
        #2;
        rst = 1'b0;
        #1;
        model_reset();
        check_all("rst.async");
        check("rst.ovr_clear", 32'(ovr_m), 32'd0);
        @(negedge clk);
        rst = 1'b1;
        send_word(4'b1010, 1'b0, 1'b0, "w1010");
        check("w1010.pout", 32'(pout_m), 32'h0000000a);
        cycle(1'b0, 1'b0, 1'b0, 1'b1, "w1010.take");

        send_word(4'b1100, 1'b0, 1'b0, "b2b.first");
        send_word(4'b0111, 1'b0, 1'b1, "b2b.second");
        check("b2b.pout", 32'(pout_m), 32'h00000007);
        check("b2b.valid", 32'(valid_m), 32'd1);
        check("b2b.ovr", 32'(ovr_m), 32'd0);
        cycle(1'b0, 1'b0, 1'b0, 1'b1, "b2b.take");

        cycle(1'b1, 1'b1, 1'b0, 1'b0, "flush.b0");
        cycle(1'b1, 1'b1, 1'b1, 1'b0, "flush.hit");
        check("flush.busy", 32'(busy_m), 32'd0);
        send_word(4'b0110, 1'b1, 1'b1, "w0110");
        check("w0110.pout", 32'(pout_m), 32'h00000006);

        send_word(4'b1000, 1'b1, 1'b1, "lsb");
        check("lsb.pout_l", 32'(pout_l), 32'h00000001);
        check("lsb.pout_m", 32'(pout_m), 32'h00000008);
        cycle(1'b0, 1'b0, 1'b0, 1'b1, "lsb.take");

`ifdef SIPO_PARITY_EN
        cycle(1'b1, 1'b1, 1'b0, 1'b0, "perr.b0");
        cycle(1'b1, 1'b1, 1'b0, 1'b0, "perr.b1");
        cycle(1'b0, 1'b1, 1'b0, 1'b0, "perr.b2");
        cycle(1'b0, 1'b1, 1'b0, 1'b0, "perr.b3");
        cycle(1'b1, 1'b1, 1'b0, 1'b0, "perr.bad");
        check("perr.pulse", 32'(perr_m), 32'd1);
        check("perr.novalid", 32'(valid_m), 32'd0);
        cycle(1'b0, 1'b0, 1'b0, 1'b0, "perr.after");
        check("perr.cleared", 32'(perr_m), 32'd0);
        send_word(4'b1100, 1'b1, 1'b1, "pgood");
        check("pgood.pout", 32'(pout_m), 32'h0000000c);
`endif

        for (int n = 0; n < 400; n++) begin
            cycle(1'($urandom), ($urandom_range(3) != 0), ($urandom_range(19) == 0),
                  1'($urandom), "rand");
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
